// File: rtl/wb_intercon_nxm_pkg.sv
// Shared definitions for the wb_intercon_nxm Wishbone interconnect.
// Holds the default widths and counts, the arbiter state encoding and an index-width helper.
package wb_intercon_nxm_pkg;

  localparam int WB_ADR_WIDTH            = 32;
  localparam int WB_DATA_WIDTH           = 32;
  localparam int INTERCON_NUM_MASTERS    = 2;
  localparam int INTERCON_NUM_SLAVES     = 4;
  localparam int INTERCON_DEC_BITS       = 8;
  localparam int INTERCON_TIMEOUT_CYCLES = 255;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_OWNED = 1'b1
  } arb_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter: one-hot grant registered one cycle after a request, held while hold_i
// stays high; on release the pointer moves to the last owner and one idle cycle follows.
module wb_rr_arbiter
  import wb_intercon_nxm_pkg::*;
#(
  parameter int N = INTERCON_NUM_MASTERS
)(
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_i,
  input  logic         hold_i,
  output logic [N-1:0] grant_o
);

  localparam int IW = idx_width(N);

  arb_state_e      state_q, state_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic            hi_found, lo_found, pick_found;
  logic [IW-1:0]   hi_idx, lo_idx, pick_idx;
  logic [N-1:0]    pick_oh;

  // Search above the pointer first, then wrap to the bottom; descending loops keep the lowest hit.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      hi_found = hi_found | (req_i[i] & (i > int'(ptr_q)));
      hi_idx   = (req_i[i] && (i > int'(ptr_q))) ? IW'(i) : hi_idx;
      lo_found = lo_found | (req_i[i] & (i <= int'(ptr_q)));
      lo_idx   = (req_i[i] && (i <= int'(ptr_q))) ? IW'(i) : lo_idx;
    end
    pick_found = hi_found | lo_found;
    pick_idx   = hi_found ? hi_idx : lo_idx;
    pick_oh    = '0;
    pick_oh[pick_idx] = 1'b1;
  end

  // Next-state logic for bus ownership.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          state_d = ARB_OWNED;
          grant_d = pick_oh;
          owner_d = pick_idx;
        end else begin
          state_d = ARB_IDLE;
          grant_d = '0;
        end
      end
      ARB_OWNED: begin
        if (!hold_i) begin
          state_d = ARB_IDLE;
          grant_d = '0;
          ptr_d   = owner_q;
        end else begin
          state_d = ARB_OWNED;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State register; the pointer resets to N-1 so master 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= IW'(N - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  assign grant_o = grant_q;

endmodule

// File: rtl/wb_intercon_nxm.sv
// NxM Wishbone classic shared-bus interconnect with round-robin arbitration and a default error slave.
// Optional watchdog enabled by defining INTERCON_TIMEOUT_EN.
module wb_intercon_nxm
  import wb_intercon_nxm_pkg::*;
#(
  parameter int NUM_MASTERS    = INTERCON_NUM_MASTERS,
  parameter int NUM_SLAVES     = INTERCON_NUM_SLAVES,
  parameter int ADR_WIDTH      = WB_ADR_WIDTH,
  parameter int DATA_WIDTH     = WB_DATA_WIDTH,
  parameter int SEL_WIDTH      = DATA_WIDTH / 8,
  parameter int DEC_BITS       = INTERCON_DEC_BITS,
  parameter logic [NUM_SLAVES*DEC_BITS-1:0] SLAVE_BASES = {8'h03, 8'h02, 8'h01, 8'h00},
  parameter int TIMEOUT_CYCLES = INTERCON_TIMEOUT_CYCLES
)(
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_MASTERS*ADR_WIDTH-1:0]  m_adr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i,
  input  logic [NUM_MASTERS*SEL_WIDTH-1:0]  m_sel_i,
  input  logic [NUM_MASTERS-1:0]            m_we_i,
  input  logic [NUM_MASTERS-1:0]            m_cyc_i,
  input  logic [NUM_MASTERS-1:0]            m_stb_i,
  output logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_o,
  output logic [NUM_MASTERS-1:0]            m_ack_o,
  output logic [NUM_MASTERS-1:0]            m_err_o,
  output logic [NUM_MASTERS-1:0]            m_rty_o,
  output logic [ADR_WIDTH-1:0]              s_adr_o,
  output logic [DATA_WIDTH-1:0]             s_dat_o,
  output logic [SEL_WIDTH-1:0]              s_sel_o,
  output logic                              s_we_o,
  output logic [NUM_SLAVES-1:0]             s_cyc_o,
  output logic [NUM_SLAVES-1:0]             s_stb_o,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0]  s_dat_i,
  input  logic [NUM_SLAVES-1:0]             s_ack_i,
  input  logic [NUM_SLAVES-1:0]             s_err_i,
  input  logic [NUM_SLAVES-1:0]             s_rty_i,
  output logic [NUM_MASTERS-1:0]            grant_o
);

  logic [NUM_MASTERS-1:0] grant;
  logic [ADR_WIDTH-1:0]   own_adr;
  logic [DATA_WIDTH-1:0]  own_dat;
  logic [SEL_WIDTH-1:0]   own_sel;
  logic                   own_we, own_cyc, own_stb;
  logic [NUM_SLAVES-1:0]  hit_v, sel_oh;
  logic                   any_hit;
  logic [DATA_WIDTH-1:0]  slv_dat;
  logic                   slv_ack, slv_err, slv_rty;
  logic                   def_err_q, def_err_d;
  logic                   tmo_fire;

  wb_rr_arbiter #(.N(NUM_MASTERS)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req_i   (m_cyc_i),
    .hold_i  (own_cyc),
    .grant_o (grant)
  );

  assign grant_o = grant;

  // Owner request mux; the grant is one-hot (or zero when idle) so an AND-OR is sufficient.
  always_comb begin
    own_adr = '0;
    own_dat = '0;
    own_sel = '0;
    own_we  = 1'b0;
    own_cyc = 1'b0;
    own_stb = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      own_adr = own_adr | (m_adr_i[i*ADR_WIDTH +: ADR_WIDTH] & {ADR_WIDTH{grant[i]}});
      own_dat = own_dat | (m_dat_i[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant[i]}});
      own_sel = own_sel | (m_sel_i[i*SEL_WIDTH +: SEL_WIDTH] & {SEL_WIDTH{grant[i]}});
      own_we  = own_we  | (m_we_i[i] & grant[i]);
      own_cyc = own_cyc | (m_cyc_i[i] & grant[i]);
      own_stb = own_stb | (m_stb_i[i] & grant[i]);
    end
  end

  // Address decode; overlapping bases resolve to the lowest slave index.
  always_comb begin
    hit_v = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      hit_v[k] = (own_adr[ADR_WIDTH-1 -: DEC_BITS] == SLAVE_BASES[k*DEC_BITS +: DEC_BITS]);
    end
    sel_oh  = hit_v & (~hit_v + NUM_SLAVES'(1'b1));
    any_hit = |hit_v;
  end

  // Slave-side forwarding and return-path mux from the selected slave.
  always_comb begin
    s_adr_o = own_adr;
    s_dat_o = own_dat;
    s_sel_o = own_sel;
    s_we_o  = own_we;
    s_cyc_o = sel_oh & {NUM_SLAVES{own_cyc}};
    s_stb_o = sel_oh & {NUM_SLAVES{own_cyc & own_stb & ~tmo_fire}};
    slv_dat = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      slv_dat = slv_dat | (s_dat_i[k*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{sel_oh[k]}});
    end
    slv_ack = |(s_ack_i & sel_oh);
    slv_err = |(s_err_i & sel_oh);
    slv_rty = |(s_rty_i & sel_oh);
  end

  // Default slave: one err per unmapped strobe, never back-to-back.
  always_comb begin
    def_err_d = own_cyc & own_stb & ~any_hit & ~def_err_q;
  end

  // Default slave error register.
  always_ff @(posedge clk) begin
    if (rst) begin
      def_err_q <= 1'b0;
    end else begin
      def_err_q <= def_err_d;
    end
  end

  // Terminations reach only the owner, and only while it still holds cyc.
  always_comb begin
    m_dat_o = '0;
    m_ack_o = '0;
    m_err_o = '0;
    m_rty_o = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      m_dat_o[i*DATA_WIDTH +: DATA_WIDTH] = grant[i] ? slv_dat : '0;
      m_ack_o[i] = grant[i] & own_cyc & slv_ack;
      m_err_o[i] = grant[i] & own_cyc & (slv_err | def_err_q | tmo_fire);
      m_rty_o[i] = grant[i] & own_cyc & slv_rty;
    end
  end

`ifdef INTERCON_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          slv_term;

  // Watchdog counts strobed cycles without a termination; fires on the TIMEOUT_CYCLES-th one.
  always_comb begin
    slv_term  = slv_ack | slv_err | slv_rty | def_err_q;
    tmo_fire  = own_cyc & own_stb & (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));
    tmo_cnt_d = (tmo_fire || slv_term || !own_cyc) ? '0
              : (own_stb ? tmo_cnt_q + TW'(1'b1) : tmo_cnt_q);
  end

  // Watchdog counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  assign tmo_fire = 1'b0;
`endif

endmodule
